// File: rtl/circular_rotator_pkg.sv
// circular_rotator_pkg: rotation direction type and a behavioural reference rotate.
package circular_rotator_pkg;
    typedef enum logic {ROT_RIGHT = 1'b0, ROT_LEFT = 1'b1} rot_dir_e;
    localparam int MAX_N = 64;
    function automatic logic [MAX_N-1:0] rot_ref(input logic [MAX_N-1:0] data, input int amt, input rot_dir_e dir, input int n);
        logic [MAX_N-1:0] mask;
        int k;
        mask = (MAX_N'(1) << n) - MAX_N'(1);
        k = dir == ROT_LEFT ? (n - amt % n) % n : amt % n;
        return ((data >> k) | (data << (n - k))) & mask;
    endfunction
endpackage

// File: rtl/circular_rotator_pipelined_if.sv
// circular_rotator_pipelined_if: upstream and downstream valid/ready channels of the rotator.
interface circular_rotator_pipelined_if
    import circular_rotator_pkg::*;
#(
    parameter int N = 8
);
    localparam int AW = $clog2(N);
    logic          up_vld;
    logic          up_rdy;
    logic [N-1:0]  up_data;
    logic [AW-1:0] up_amt;
    rot_dir_e      up_dir;
    logic          down_vld;
    logic          down_rdy;
    logic [N-1:0]  down_data;
    modport master (
        output up_vld, up_data, up_amt, up_dir, down_rdy,
        input  up_rdy, down_vld, down_data
    );
    modport slave (
        input  up_vld, up_data, up_amt, up_dir, down_rdy,
        output up_rdy, down_vld, down_data
    );
endinterface

// File: rtl/circular_rotator_stage.sv
// circular_rotator_stage: rotates din by SH in direction dir when en is set, else passes it.
module circular_rotator_stage
    import circular_rotator_pkg::*;
#(
    parameter int N  = 8,
    parameter int SH = 1
) (
    input  logic         en,
    input  rot_dir_e     dir,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);
    always_comb dout = !en ? din : dir == ROT_LEFT ? {din[N-SH-1:0], din[N-1:N-SH]} : {din[SH-1:0], din[N-1:SH]};
endmodule

// File: rtl/circular_rotator_pipelined.sv
// circular_rotator_pipelined: valid/ready rotator with one pipeline stage per amount bit.
module circular_rotator_pipelined
    import circular_rotator_pkg::*;
#(
    parameter  int N  = 8,
    localparam int AW = $clog2(N)
) (
    input  logic clk,
    input  logic rst_n,
    circular_rotator_pipelined_if.slave bus
);
    logic          vld_q [AW];
    logic          vld_d [AW];
    logic [N-1:0]  data_q [AW];
    logic [N-1:0]  data_d [AW];
    logic [AW-1:0] amt_q [AW];
    logic [AW-1:0] amt_d [AW];
    rot_dir_e      dir_q [AW];
    rot_dir_e      dir_d [AW];
    logic          in_vld [AW];
    logic [N-1:0]  in_data [AW];
    logic [AW-1:0] in_amt [AW];
    rot_dir_e      in_dir [AW];
    logic [N-1:0]  rot [AW];
    logic [AW:0]   adv;
    always_comb begin
        in_vld[0]  = bus.up_vld;
        in_data[0] = bus.up_data;
        in_amt[0]  = bus.up_amt;
        in_dir[0]  = bus.up_dir;
        for (int s = 1; s < AW; s++) begin
            in_vld[s]  = vld_q[s-1];
            in_data[s] = data_q[s-1];
            in_amt[s]  = amt_q[s-1];
            in_dir[s]  = dir_q[s-1];
        end
    end
    for (genvar s = 0; s < AW; s++) begin : g_stage
        circular_rotator_stage #(.N(N), .SH(1 << s)) u_stage (
            .en  (in_amt[s][s]),
            .dir (in_dir[s]),
            .din (in_data[s]),
            .dout(rot[s])
        );
    end
    // A stage advances if it is empty or the stage after it advances, so bubbles collapse.
    always_comb begin
        adv[AW] = bus.down_rdy;
        for (int s = AW - 1; s >= 0; s--) adv[s] = !vld_q[s] || adv[s+1];
        for (int s = 0; s < AW; s++) begin
            vld_d[s]  = adv[s] ? in_vld[s] : vld_q[s];
            data_d[s] = adv[s] ? rot[s] : data_q[s];
            amt_d[s]  = adv[s] ? in_amt[s] : amt_q[s];
            dir_d[s]  = adv[s] ? in_dir[s] : dir_q[s];
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < AW; s++) begin
                vld_q[s]  <= 1'b0;
                data_q[s] <= '0;
                amt_q[s]  <= '0;
                dir_q[s]  <= ROT_RIGHT;
            end
        end else begin
            for (int s = 0; s < AW; s++) begin
                vld_q[s]  <= vld_d[s];
                data_q[s] <= data_d[s];
                amt_q[s]  <= amt_d[s];
                dir_q[s]  <= dir_d[s];
            end
        end
    end
    assign bus.up_rdy    = adv[0];
    assign bus.down_vld  = vld_q[AW-1];
    assign bus.down_data = data_q[AW-1];
endmodule

// File: doc/circular_rotator_pipelined.md
# circular_rotator_pipelined

Variable-amount, bidirectional circular rotator for N-bit words, built as a pipeline with one stage per amount bit and a valid/ready handshake on both sides. It is the run-time counterpart of our fixed-amount left/right circular-shift modules: the same rotation, but the amount and direction arrive with each word. Rotating left by k and then right by k, or the reverse, restores the original word. It sits between any two valid/ready stages of the arithmetic/pipelining datapath and fully supports backpressure.

## Interface
- N, 8, word width; must be a power of two, N ≥ 2
- AW, $clog2(N), amount width (derived; do not override)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- up_vld  in  1  input word valid
- up_rdy  out  1  rotator can accept input this cycle
- up_data  in  N  word to rotate
- up_amt  in  AW  rotation amount, 0..N-1
- up_dir  in  1  0 = rotate right, 1 = rotate left
- down_vld  out  1  output word valid
- down_rdy  in  1  downstream accepts output
- down_data  out  N  rotated word

## Operation
- Reset is asynchronous and active-low (fixed). While rst_n is low: every stage valid is 0, every data/amount/direction register is 0, and down_vld=0 and down_data=0.
- Rotation definition:
  - Right by k: bit i of the result is a[(i+k) mod N]. Example: ABCDEFGH right 3 gives FGHABCDE.
  - Left by k: bit i of the result is a[(i−k) mod N]. Example: ABCDEFGH left 3 gives DEFGHABC.
- Pipeline has AW stages, indexed 0..AW−1. Stage s holds:
  - vld[s], data[s]
  - amt and dir, which travel with the word
- Stage s rotates its incoming word by 2^s in direction dir when amount bit s is 1; otherwise it passes the word unchanged.
- Stage 0 takes its word from the up_* inputs. down_data = data[AW−1] and down_vld = vld[AW−1].
- Stage s accepts a new word when adv[s] = !vld[s] || adv[s+1], with adv[AW] = down_rdy.
- Handshake:
  - up_rdy = adv[0].
  - A transfer happens on a clock edge where up_vld && up_rdy.
  - Stage s loads from stage s−1 when adv[s]; it loads vld[s−1] together with the data, so bubbles propagate.
  - A stage whose adv is 0 holds all of its registers.
- Bubbles collapse: an empty stage accepts even when downstream is stalled.
- Simultaneous events: in one cycle, output consumption and input acceptance both occur and throughput stays at 1 word/cycle.
- Amount 0, in either direction, returns the input unchanged. Amount bits wider than AW do not exist, so the amount is always reduced mod N.
- Reset asserted mid-operation drops every in-flight word immediately, with no partial output. After release, the first accepted word emerges normally.
- Stability: while down_vld && !down_rdy, down_data does not change.
- up_data, up_amt and up_dir are sampled only on a transfer edge. Other values are ignored.

## Timing
- Latency: exactly AW cycles from the input transfer edge to down_vld=1, when there is no backpressure. For N=8, latency is 3.
- Throughput: one word per cycle with down_rdy held high.
- up_rdy depends combinationally on down_rdy through the adv chain. There is no combinational path from up_* to down_*.
- Occupancy: at most AW words in flight.
- Output order equals input order; words are never dropped or duplicated.

## Structure
- Package circular_rotator_pkg holds:
  - typedef enum logic {ROT_RIGHT=1'b0, ROT_LEFT=1'b1} rot_dir_e
  - function rot_ref(data, amt, dir), the behavioural reference used by the testbench only
- Sub-module circular_rotator_stage #(N, SH):
  - combinational stage: a fixed rotate by SH, selected by amount bit and direction
  - built from bit-slice concatenation
  - instantiated AW times in a generate loop with SH = 2^s
- Top level holds the stage registers and the adv chain.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with up_vld=1. Required: down_vld=0 and down_data=0 throughout, and no word emerges after release unless it was accepted after release.
- Directed rotation, N=8, down_rdy=1. Send these three words, which must emerge on consecutive cycles 3 cycles after entry:
  - 8'b1000_0001, right 3 → 8'b0011_0000
  - 8'b1000_0001, left 3 → 8'b0000_1100
  - 8'hA5, amt 0, right → 8'hA5
- Round trip: for every amt 0..7, rotate 8'hC3 left by amt, then feed the result back right by amt. Required: 8'hC3 every time.
- Backpressure: stream 8 words at full rate while down_rdy toggles every 2 cycles. Required:
  - no loss, duplication or reordering
  - down_data stable while stalled
  - up_rdy=0 only when all 3 stages are full and down_rdy=0
- Reset mid-stream: assert rst_n low with 3 words in flight. Required: down_vld drops asynchronously before the next edge, and the post-release word emerges with latency 3.
- Random: 10k transactions against rot_ref with random up_vld/down_rdy, for N=8 and N=32. Required: zero mismatches.
